// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the cpu_mc core: opcodes, FSM states and instruction field layout.
package cpu_mc_pkg;

    localparam int OP_W      = 6;
    localparam int IMM_W     = 32;
    localparam int LDI_SHIFT = 32;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 6'd0,
        OP_SUB  = 6'd1,
        OP_AND  = 6'd2,
        OP_OR   = 6'd3,
        OP_XOR  = 6'd4,
        OP_LDI  = 6'd5,
        OP_LD   = 6'd6,
        OP_ST   = 6'd7,
        OP_CEQ  = 6'd8,
        OP_CLTU = 6'd9,
        OP_JMP  = 6'd10,
        OP_BRF  = 6'd11,
        OP_HALT = 6'd63
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_e;

    // Field k (0=ra, 1=rb, 2=rd, 3=hl) starts right after the opcode, k register-index widths in.
    function automatic int field_lsb(input int rw, input int k);
        return OP_W + k * rw;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// General register file plus per-register condition flags, cleared asynchronously.
module cpu_regfile
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [$clog2(NREGS)-1:0]   ra_idx,
    input  logic [$clog2(NREGS)-1:0]   rb_idx,
    output logic [DATA_W-1:0]          ra_data,
    output logic [DATA_W-1:0]          rb_data,
    input  logic [$clog2(NREGS)-1:0]   fa_idx,
    input  logic [$clog2(NREGS)-1:0]   fb_idx,
    output logic                       fa_data,
    output logic                       fb_data,
    input  logic [$clog2(NREGS)-1:0]   wr_idx,
    input  logic                       reg_we,
    input  logic [DATA_W-1:0]          reg_wdata,
    input  logic                       flag_we,
    input  logic                       flag_wdata
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  flags;

    assign ra_data = regs[ra_idx];
    assign rb_data = regs[rb_idx];
    assign fa_data = flags[fa_idx];
    assign fb_data = flags[fb_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            flags <= '0;
        end else begin
            if (reg_we) begin
                regs[wr_idx] <= reg_wdata;
            end
            if (flag_we) begin
                flags[wr_idx] <= flag_wdata;
            end
        end
    end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle CPU core: IDLE -> FETCH -> EXEC [-> MEM] over a single req/ack memory port.
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                ADDR_W   = 64,
    parameter int                NREGS    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted
);

    localparam int RW    = $clog2(NREGS);
    localparam int RA_L  = field_lsb(RW, 0);
    localparam int RB_L  = field_lsb(RW, 1);
    localparam int RD_L  = field_lsb(RW, 2);
    localparam int HL_B  = field_lsb(RW, 3);

    state_e            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx, ea;
    logic [DATA_W-1:0] instr;

    logic [OP_W-1:0]   op;
    logic [RW-1:0]     ra, rb, rd, rsel_b;
    logic              hl;
    logic [IMM_W-1:0]  imm;

    logic [DATA_W-1:0] r_a, r_b;
    logic              f_a, f_d;
    logic [DATA_W-1:0] alu_y;
    logic              rf_we, fl_we, fl_wdata;
    logic [DATA_W-1:0] rf_wdata;
    logic              unused_bits;

    assign op  = instr[OP_W-1:0];
    assign ra  = instr[RA_L +: RW];
    assign rb  = instr[RB_L +: RW];
    assign rd  = instr[RD_L +: RW];
    assign hl  = instr[HL_B];
    assign imm = instr[DATA_W-1 -: IMM_W];

    // LDI with hl=1 merges into the old destination value, so port B reads rd for it.
    assign rsel_b = (op == OP_LDI) ? rd : rb;

    assign unused_bits = ^{instr, f_d};

    cpu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clock      (clock),
        .reset      (reset),
        .ra_idx     (ra),
        .rb_idx     (rsel_b),
        .ra_data    (r_a),
        .rb_data    (r_b),
        .fa_idx     (ra),
        .fb_idx     (rd),
        .fa_data    (f_a),
        .fb_data    (f_d),
        .wr_idx     (rd),
        .reg_we     (rf_we),
        .reg_wdata  (rf_wdata),
        .flag_we    (fl_we),
        .flag_wdata (fl_wdata)
    );

    always_comb begin
        alu_y = '0;
        unique case (op)
            OP_ADD:  alu_y = r_a + r_b;
            OP_SUB:  alu_y = r_a - r_b;
            OP_AND:  alu_y = r_a & r_b;
            OP_OR:   alu_y = r_a | r_b;
            OP_XOR:  alu_y = r_a ^ r_b;
            OP_LDI:  alu_y = hl ? DATA_W'((64'(imm) << LDI_SHIFT) | 64'(r_b[LDI_SHIFT-1:0]))
                                : DATA_W'(imm);
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = alu_y;
        fl_we    = 1'b0;
        fl_wdata = 1'b0;
        if (state == S_EXEC) begin
            unique case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI: rf_we = 1'b1;
                OP_CEQ: begin
                    fl_we    = 1'b1;
                    fl_wdata = (r_a == r_b);
                end
                OP_CLTU: begin
                    fl_we    = 1'b1;
                    fl_wdata = (r_a < r_b);
                end
                default: ;
            endcase
        end else if (state == S_MEM && op == OP_LD && mem_ack) begin
            rf_we    = 1'b1;
            rf_wdata = mem_rdata;
        end
    end

    // Memory outputs depend on registered state only; mem_ack steers next state and pc.
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        halted    = 1'b0;
        unique case (state)
            S_IDLE:  state_nx = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ack) begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nx = S_FETCH;
                pc_nx    = pc + ADDR_W'(1);
                unique case (op)
                    OP_JMP:  pc_nx = ADDR_W'(r_a);
                    OP_BRF: begin
                        if (f_a) begin
                            pc_nx = ADDR_W'(imm);
                        end
                    end
                    OP_LD, OP_ST: begin
                        state_nx = S_MEM;
                        pc_nx    = pc;
                    end
                    OP_HALT: begin
                        state_nx = S_HALT;
                        pc_nx    = pc;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = ea;
                if (op == OP_ST) begin
                    mem_we    = 1'b1;
                    mem_wdata = r_b;
                end
                if (mem_ack) begin
                    state_nx = S_FETCH;
                    pc_nx    = pc + ADDR_W'(1);
                end
            end
            S_HALT:  halted = 1'b1;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            instr <= '0;
            ea    <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == S_FETCH && mem_ack) begin
                instr <= mem_rdata;
            end
            if (state == S_EXEC) begin
                ea <= ADDR_W'(r_a) + ADDR_W'(imm);
            end
        end
    end

endmodule
